// File: rtl/txtsu_pkg.sv
// Shared entry type and helpers for the TX timestamp collector.
package txtsu_pkg;

  localparam int c_TXTSU_ENTRY_WIDTH = 53;

  typedef struct packed {
    logic [4:0]  port_id;
    logic [15:0] frame_id;
    logic [31:0] tsval;
  } t_txtsu_entry;

  // Index width that still works for a single-port build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/txtsu_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index and wraps.
module txtsu_rr_arbiter
  import txtsu_pkg::*;
#(
  parameter int g_width = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [g_width-1:0]            req,
  input  logic [g_width-1:0]            mask,
  input  logic                          advance,
  output logic [g_width-1:0]            grant,
  output logic [idx_width(g_width)-1:0] grant_idx,
  output logic                          grant_valid
);

  localparam int IW = idx_width(g_width);

  logic [g_width-1:0] eligible;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      hi_idx;
  logic [IW-1:0]      lo_idx;
  logic               found_hi;
  logic               found_lo;

  assign eligible = req & ~mask;

  // Lowest eligible index above last_grant wins, else lowest at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = g_width - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (IW'(i) > last_grant) begin
          found_hi = 1'b1;
          hi_idx   = IW'(i);
        end else begin
          found_lo = 1'b1;
          lo_idx   = IW'(i);
        end
      end
    end
    grant_valid = found_hi | found_lo;
    grant_idx   = found_hi ? hi_idx : lo_idx;
    grant       = '0;
    for (int i = 0; i < g_width; i++) begin
      grant[i] = grant_valid && (IW'(i) == grant_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(g_width - 1);
    end else if (advance && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/txtsu_collector.sv
// Merges per-endpoint TXTSU streams into one show-ahead FIFO with
// round-robin capture and a selectable full policy.
module txtsu_collector
  import txtsu_pkg::*;
#(
  parameter int g_num_ports        = 2,
  parameter int g_fifo_depth       = 16,
  parameter int g_drop_on_full     = 0,
  parameter int g_override_port_id = 0
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_n_i,
  input  logic [g_num_ports-1:0]        txtsu_valid_i,
  input  logic [5*g_num_ports-1:0]      txtsu_port_id_i,
  input  logic [16*g_num_ports-1:0]     txtsu_frame_id_i,
  input  logic [32*g_num_ports-1:0]     txtsu_tsval_i,
  output logic [g_num_ports-1:0]        txtsu_ack_o,
  output logic                          txtsu_valid_o,
  output logic [4:0]                    txtsu_port_id_o,
  output logic [15:0]                   txtsu_frame_id_o,
  output logic [31:0]                   txtsu_tsval_o,
  input  logic                          txtsu_ack_i,
  output logic [15:0]                   drop_cnt_o,
  output logic [$clog2(g_fifo_depth):0] fifo_level_o
);

  localparam int AW   = $clog2(g_fifo_depth);
  localparam int PW   = AW + 1;
  localparam int IW   = idx_width(g_num_ports);
  localparam bit DROP = (g_drop_on_full != 0);
  localparam bit OVR  = (g_override_port_id != 0);

  t_txtsu_entry           mem [g_fifo_depth];
  t_txtsu_entry           in_entry;
  t_txtsu_entry           head;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [g_num_ports-1:0] ack_q;
  logic [g_num_ports-1:0] grant;
  logic [IW-1:0]          grant_idx;
  logic                   grant_valid;
  logic [15:0]            drop_cnt;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   capture;
  logic                   push;
  logic                   drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = txtsu_ack_i && !empty;

  // A same-cycle pop frees the slot, so full+pop behaves as not full.
  assign capture = grant_valid && (!full || pop || DROP);
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  txtsu_rr_arbiter #(
    .g_width (g_num_ports)
  ) u_arbiter (
    .clk         (clk_sys_i),
    .rst_n       (rst_n_i),
    .req         (txtsu_valid_i),
    .mask        (ack_q),
    .advance     (capture),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    in_entry = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      if (grant[i]) begin
        in_entry.port_id  = txtsu_port_id_i[5*i +: 5];
        in_entry.frame_id = txtsu_frame_id_i[16*i +: 16];
        in_entry.tsval    = txtsu_tsval_i[32*i +: 32];
      end
    end
    if (OVR) begin
      in_entry.port_id = 5'(grant_idx);
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ack_q    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < g_fifo_depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ack_q <= capture ? grant : '0;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_entry;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign head             = mem[rd_ptr[AW-1:0]];
  assign txtsu_ack_o      = ack_q;
  assign txtsu_valid_o    = !empty;
  assign txtsu_port_id_o  = head.port_id;
  assign txtsu_frame_id_o = head.frame_id;
  assign txtsu_tsval_o    = head.tsval;
  assign drop_cnt_o       = drop_cnt;
  assign fifo_level_o     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_txtsu_collector.sv
// Random and directed stimulus for two collector builds (backpressure and
// drop/override), checked every cycle against a queue-level reference model.
module tb_txtsu_collector;

  localparam int N       = 4;
  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    valid_in  [2];
  logic [5*N-1:0]  pid_in    [2];
  logic [16*N-1:0] fid_in    [2];
  logic [32*N-1:0] ts_in     [2];
  logic [N-1:0]    ack_out   [2];
  logic            valid_out [2];
  logic [4:0]      pid_out   [2];
  logic [15:0]     fid_out   [2];
  logic [31:0]     ts_out    [2];
  logic            cons_ack  [2];
  logic [15:0]     drop_out  [2];
  logic [2:0]      level_a;
  logic [3:0]      level_b;

  txtsu_collector #(
    .g_num_ports        (N),
    .g_fifo_depth       (DEPTH_A),
    .g_drop_on_full     (0),
    .g_override_port_id (0)
  ) dut_a (
    .clk_sys_i        (clk),
    .rst_n_i          (rst_n),
    .txtsu_valid_i    (valid_in[0]),
    .txtsu_port_id_i  (pid_in[0]),
    .txtsu_frame_id_i (fid_in[0]),
    .txtsu_tsval_i    (ts_in[0]),
    .txtsu_ack_o      (ack_out[0]),
    .txtsu_valid_o    (valid_out[0]),
    .txtsu_port_id_o  (pid_out[0]),
    .txtsu_frame_id_o (fid_out[0]),
    .txtsu_tsval_o    (ts_out[0]),
    .txtsu_ack_i      (cons_ack[0]),
    .drop_cnt_o       (drop_out[0]),
    .fifo_level_o     (level_a)
  );

  txtsu_collector #(
    .g_num_ports        (N),
    .g_fifo_depth       (DEPTH_B),
    .g_drop_on_full     (1),
    .g_override_port_id (1)
  ) dut_b (
    .clk_sys_i        (clk),
    .rst_n_i          (rst_n),
    .txtsu_valid_i    (valid_in[1]),
    .txtsu_port_id_i  (pid_in[1]),
    .txtsu_frame_id_i (fid_in[1]),
    .txtsu_tsval_i    (ts_in[1]),
    .txtsu_ack_o      (ack_out[1]),
    .txtsu_valid_o    (valid_out[1]),
    .txtsu_port_id_o  (pid_out[1]),
    .txtsu_frame_id_o (fid_out[1]),
    .txtsu_tsval_o    (ts_out[1]),
    .txtsu_ack_i      (cons_ack[1]),
    .drop_cnt_o       (drop_out[1]),
    .fifo_level_o     (level_b)
  );

  int          depth_cfg [2];
  bit          drop_cfg  [2];
  bit          ovr_cfg   [2];
  logic [52:0] mfifo     [2][8];
  int          mhead     [2];
  int          mcount    [2];
  int          mlast     [2];
  int          mdrop     [2];
  logic [N-1:0] m_ack    [2];

  bit          src_valid [2][N];
  bit          src_done  [2][N];
  logic [4:0]  src_pid   [2][N];
  logic [15:0] src_fid   [2][N];
  logic [31:0] src_ts    [2][N];

  int          offer_pct = 0;
  int          cons_pct  = 0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  logic [15:0] next_fid  = 16'h0100;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] level_of(input int d);
    return (d == 0) ? 64'(level_a) : 64'(level_b);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mhead[d]  = 0;
      mcount[d] = 0;
      mlast[d]  = N - 1;
      mdrop[d]  = 0;
      m_ack[d]  = '0;
      cons_ack[d] = 1'b0;
      for (int p = 0; p < N; p++) begin
        src_valid[d][p] = 1'b0;
        src_done[d][p]  = 1'b0;
      end
    end
  endtask

  task automatic present(input int d, input int p, input logic [4:0] pid,
                         input logic [15:0] fid, input logic [31:0] ts);
    src_valid[d][p] = 1'b1;
    src_done[d][p]  = 1'b0;
    src_pid[d][p]   = pid;
    src_fid[d][p]   = fid;
    src_ts[d][p]    = ts;
  endtask

  task automatic drive_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) begin
        valid_in[d][p]          = src_valid[d][p];
        pid_in[d][5*p +: 5]     = src_pid[d][p];
        fid_in[d][16*p +: 16]   = src_fid[d][p];
        ts_in[d][32*p +: 32]    = src_ts[d][p];
      end
    end
  endtask

  // What the next clock edge must do, in queue terms.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [N-1:0] nack;
      g    = -1;
      nack = '0;
      if (cons_ack[d] && mcount[d] > 0) begin
        mhead[d]  = (mhead[d] + 1) % depth_cfg[d];
        mcount[d] = mcount[d] - 1;
      end
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (mlast[d] + k) % N;
        if (g < 0 && src_valid[d][p] && !m_ack[d][p]) g = p;
      end
      if (g >= 0) begin
        if (mcount[d] < depth_cfg[d]) begin
          mfifo[d][(mhead[d] + mcount[d]) % depth_cfg[d]] =
            {ovr_cfg[d] ? 5'(g) : src_pid[d][g], src_fid[d][g], src_ts[d][g]};
          mcount[d] = mcount[d] + 1;
          mlast[d]  = g;
          nack[g]   = 1'b1;
        end else if (drop_cfg[d]) begin
          if (mdrop[d] < 65535) mdrop[d] = mdrop[d] + 1;
          mlast[d] = g;
          nack[g]  = 1'b1;
        end
      end
      m_ack[d] = nack;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("ack[%0d]", d), 64'(ack_out[d]), 64'(m_ack[d]));
      checkOutput($sformatf("valid[%0d]", d), 64'(valid_out[d]), 64'(mcount[d] > 0));
      checkOutput($sformatf("level[%0d]", d), level_of(d), 64'(mcount[d]));
      checkOutput($sformatf("drop_cnt[%0d]", d), 64'(drop_out[d]), 64'(mdrop[d]));
      if (mcount[d] > 0)
        checkOutput($sformatf("head[%0d]", d), 64'({pid_out[d], fid_out[d], ts_out[d]}),
                    64'(mfifo[d][mhead[d]]));
    end
  endtask

  task automatic reset_check(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_ack[%0d]", tag, d), 64'(ack_out[d]), 64'(0));
      checkOutput($sformatf("%s_valid[%0d]", tag, d), 64'(valid_out[d]), 64'(0));
      checkOutput($sformatf("%s_data[%0d]", tag, d),
                  64'({pid_out[d], fid_out[d], ts_out[d]}), 64'(0));
      checkOutput($sformatf("%s_drop[%0d]", tag, d), 64'(drop_out[d]), 64'(0));
      checkOutput($sformatf("%s_level[%0d]", tag, d), level_of(d), 64'(0));
    end
  endtask

  // One cycle: check, let sources react to acks, drive, advance model.
  task automatic applyStimulus();
    @(negedge clk);
    check_all();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) begin
        if (m_ack[d][p]) begin
          src_done[d][p] = 1'b1;
        end else if (src_done[d][p] || !src_valid[d][p]) begin
          src_done[d][p]  = 1'b0;
          src_valid[d][p] = 1'b0;
          if (int'($urandom_range(0, 99)) < offer_pct) begin
            present(d, p, 5'($urandom), next_fid, $urandom);
            next_fid = next_fid + 16'd1;
          end
        end
      end
      cons_ack[d] = (int'($urandom_range(0, 99)) < cons_pct);
    end
    drive_inputs();
    model_step();
  endtask

  initial begin
    depth_cfg = '{DEPTH_A, DEPTH_B};
    drop_cfg  = '{1'b0, 1'b1};
    ovr_cfg   = '{1'b0, 1'b1};
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++) begin
        src_pid[d][p] = '0;
        src_fid[d][p] = '0;
        src_ts[d][p]  = '0;
      end
    model_reset();
    drive_inputs();
    #1 rst_n = 1'b0;
    #1 reset_check("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus();

    for (int d = 0; d < 2; d++) present(d, 2, 5'h02, 16'h0010, 32'h12345678);
    repeat (3) applyStimulus();
    cons_pct = 100;
    repeat (3) applyStimulus();

    // All ports at once; port 3 carries port_id 0x1F to exercise override.
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++)
        present(d, p, (p == 3) ? 5'h1F : 5'(p), 16'h0020 + 16'(p), $urandom);
    repeat (10) applyStimulus();

    cons_pct  = 0;
    offer_pct = 100;
    repeat (14) applyStimulus();
    checkOutput("full_level_a", 64'(level_a), 64'(DEPTH_A));
    checkOutput("full_level_b", 64'(level_b), 64'(DEPTH_B));
    cons_pct = 100;
    applyStimulus();
    cons_pct = 0;
    repeat (4) applyStimulus();
    offer_pct = 0;
    cons_pct  = 100;
    repeat (12) applyStimulus();

    for (int blk = 0; blk < 15; blk++) begin
      offer_pct = int'($urandom_range(10, 100));
      cons_pct  = int'($urandom_range(0, 100));
      repeat (20) applyStimulus();
    end

    offer_pct = 70;
    cons_pct  = 20;
    repeat (8) applyStimulus();
    rst_n = 1'b0;
    model_reset();
    drive_inputs();
    #1 reset_check("mid");
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    offer_pct = 0;
    cons_pct  = 0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++)
        present(d, p, 5'(p + 8), 16'h0200 + 16'(p), $urandom);
    repeat (2) applyStimulus();
    checkOutput("first_grant_a", 64'(ack_out[0]), 64'(4'b0001));
    checkOutput("first_grant_b", 64'(ack_out[1]), 64'(4'b0001));

    for (int blk = 0; blk < 10; blk++) begin
      offer_pct = int'($urandom_range(20, 100));
      cons_pct  = int'($urandom_range(0, 100));
      repeat (20) applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/txtsu_collector.md
# txtsu_collector

Parametrised TX-timestamp collector that merges the TXTSU streams of `g_num_ports` endpoints into one buffered stream for the NIC/host. It sits between the endpoints' `txtsu_*` outputs and a single consumer speaking the same valid/ack protocol. Compared with one endpoint wired point-to-point to a consumer, it adds:
- round-robin arbitration between ports;
- a FIFO of configurable depth;
- optional port-id substitution;
- a selectable full policy (backpressure or drop-and-count).

## Interface
Parameters:
- `g_num_ports`, 2, number of endpoint TXTSU inputs (1..32).
- `g_fifo_depth`, 16, FIFO entries; power of two, at least 2.
- `g_drop_on_full`, 0: 0 = hold off ack while full; 1 = ack and discard while full.
- `g_override_port_id`, 0: 1 = replace the incoming port_id with the input index.

Ports:
- `clk_sys_i`  in  1  system clock; every port is synchronous to it.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `txtsu_valid_i`  in  g_num_ports  per-port entry valid.
- `txtsu_port_id_i`  in  5*g_num_ports  port i occupies bits [5i+4:5i].
- `txtsu_frame_id_i`  in  16*g_num_ports  frame id per port.
- `txtsu_tsval_i`  in  32*g_num_ports  timestamp per port.
- `txtsu_ack_o`  out  g_num_ports  one-cycle capture acknowledge per port.
- `txtsu_valid_o`  out  1  FIFO head valid (FIFO non-empty).
- `txtsu_port_id_o`  out  5  head port id.
- `txtsu_frame_id_o`  out  16  head frame id.
- `txtsu_tsval_o`  out  32  head timestamp.
- `txtsu_ack_i`  in  1  consumer pop; ignored while `txtsu_valid_o` = 0.
- `drop_cnt_o`  out  16  dropped entries; saturates at 0xFFFF.
- `fifo_level_o`  out  clog2(g_fifo_depth)+1  current occupancy.

## Operation
- Input protocol:
  - Source holds valid and data stable until it sees ack.
  - Ack is a single-cycle pulse.
  - Source drops valid (or presents the next entry) in the cycle after ack.
- Eligibility: port i is eligible in cycle t when `txtsu_valid_i[i]` = 1 and `txtsu_ack_o[i]` = 0 in t. This mask stops the same entry being captured twice.
- Arbitration:
  - Round-robin, at most one grant per cycle.
  - Search starts at last_grant+1 and wraps modulo g_num_ports.
  - last_grant resets to g_num_ports-1, so port 0 has first priority after reset.
- Capture in cycle t when a port is granted and the FIFO is not full (or g_drop_on_full = 1):
  - The 53-bit entry {port_id, frame_id, tsval} is written at the end of t. With `g_override_port_id` = 1, port_id is the 5-bit grant index.
  - `txtsu_ack_o[grant]` = 1 in cycle t+1 (registered).
- FIFO full, g_drop_on_full = 0: no grant, no ack, last_grant unchanged; sources wait.
- FIFO full, g_drop_on_full = 1: the grant proceeds and ack is issued, but nothing is written and `drop_cnt_o` increments (saturating).
- Output side:
  - Show-ahead FIFO: the head is always presented on `txtsu_*_o`.
  - `txtsu_ack_i` high while `txtsu_valid_o` = 1 pops one entry at the end of the cycle.
- Simultaneous push and pop: allowed in every state.
  - When full, a same-cycle pop frees the slot for that cycle's push, so full+pop counts as not full.
  - Level is unchanged.
- Empty FIFO: `txtsu_ack_i` is ignored and the level never underflows.

## Timing
- Reset values:
  - `txtsu_ack_o` = 0, `txtsu_valid_o` = 0, data outputs = 0.
  - `drop_cnt_o` = 0, `fifo_level_o` = 0.
  - FIFO pointers cleared, last_grant = g_num_ports-1.
- Latency:
  - Input valid in cycle t with an empty FIFO gives ack in t+1 and `txtsu_valid_o` in t+1.
  - Sustained throughput: one entry per cycle across ports. A single port manages one entry every 2 cycles because of the ack mask.
- Pointers are clog2(g_fifo_depth)+1 bits and wrap naturally.
  - full = MSBs differ and LSBs equal.
  - empty = pointers equal.
- Reset asserted mid-operation: all state clears asynchronously; in-flight entries and pending acks are discarded.
- `fifo_level_o` and `drop_cnt_o` are registered and reflect the push/pop of the previous cycle.

## Structure
- Package `txtsu_pkg`:
  - typedef `t_txtsu_entry` (packed struct: port_id[4:0], frame_id[15:0], tsval[31:0]);
  - constant `c_TXTSU_ENTRY_WIDTH` = 53.
- Sub-module `txtsu_rr_arbiter`, parametrised by width. Inputs: request vector, mask, advance enable. Outputs: one-hot grant, grant index. Holds last_grant internally.
- The FIFO is an inline register/RAM array; no separate module.

## Test plan
- Single port, g_num_ports = 4: port 2 presents frame_id 0x0010, ts 0x12345678 in cycle 5.
  - Ack on port 2 in cycle 6 only.
  - Output valid in cycle 6 with identical data.
- All 4 ports valid in the same cycle, consumer acking continuously.
  - Acks in order 0,1,2,3 on consecutive cycles.
  - Output frame_ids emerge in the same order.
- g_fifo_depth = 4, g_drop_on_full = 0, no consumer ack, 6 entries offered.
  - 4 acks, then no ack; level = 4.
  - One consumer pop lets exactly one more entry in.
- g_drop_on_full = 1, FIFO full, 3 further entries offered.
  - All 3 acked; `drop_cnt_o` = 3; FIFO contents unchanged.
- g_override_port_id = 1: port 3 sends port_id 0x1F.
  - Output port_id = 3.
- Reset pulsed with 2 entries queued and an ack pending.
  - All outputs return to reset values.
  - Next capture is granted to port 0.
